// File: rtl/alu_flag_unit.sv
// Processor status flag register with per-bit ALU updates, a branch-condition evaluator
// behind a valid/ready result register, and a LIFO of saved flag sets for interrupts.
module alu_flag_unit #(
  parameter int SHADOW_DEPTH = 4,
  parameter bit BYPASS       = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] flags_in,
  input  logic [4:0] flag_we,
  input  logic       cond_valid,
  input  logic [3:0] cond_code,
  output logic       cond_ready,
  output logic       taken_valid,
  output logic       taken,
  input  logic       taken_ready,
  input  logic       save,
  input  logic       restore,
  output logic [4:0] psr,
  output logic       stack_empty,
  output logic       stack_full,
  output logic       stack_err
);

  localparam int SPW  = $clog2(SHADOW_DEPTH + 1);
  localparam int IDXW = $clog2(SHADOW_DEPTH);

  logic [SPW-1:0]  sp;
  logic [4:0]      stackMem [SHADOW_DEPTH];
  logic [IDXW-1:0] pushIdx;
  logic [IDXW-1:0] popIdx;
  logic            doSave;
  logic            doRestore;
  logic            stackFault;
  logic [4:0]      effFlags;
  logic            condTrue;
  logic            accept;

  assign stack_empty = (sp == '0);
  assign stack_full  = (sp == SPW'(SHADOW_DEPTH));
  assign pushIdx     = sp[IDXW-1:0];
  assign popIdx      = IDXW'(sp - 1'b1);

  // Restore wins over save when both arrive together.
  assign doRestore  = restore & ~stack_empty;
  assign doSave     = save & ~restore & ~stack_full;
  assign stackFault = (restore & stack_empty) | (save & ~restore & stack_full);

  assign cond_ready = ~taken_valid | taken_ready;
  assign accept     = cond_valid & cond_ready;

  // A restore overwrites psr wholesale, so same-cycle ALU flags are never forwarded then.
  always_comb begin
    if (BYPASS && !restore) effFlags = (flag_we & flags_in) | (~flag_we & psr);
    else                    effFlags = psr;
  end

  always_comb begin
    logic fC, fL, fF, fZ, fN;
    {fC, fL, fF, fZ, fN} = effFlags;
    condTrue = 1'b0;
    case (cond_code)
      4'h0: condTrue = fZ;
      4'h1: condTrue = ~fZ;
      4'h2: condTrue = fC;
      4'h3: condTrue = ~fC;
      4'h4: condTrue = fL;
      4'h5: condTrue = ~fL;
      4'h6: condTrue = fN;
      4'h7: condTrue = ~fN;
      4'h8: condTrue = fF;
      4'h9: condTrue = ~fF;
      4'hA: condTrue = ~fL & ~fZ;
      4'hB: condTrue = fL | fZ;
      4'hC: condTrue = ~fN & ~fZ;
      4'hD: condTrue = fN | fZ;
      4'hE: condTrue = 1'b1;
      default: condTrue = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psr       <= '0;
      sp        <= '0;
      stack_err <= 1'b0;
    end else begin
      if (doRestore) begin
        psr <= stackMem[popIdx];
        sp  <= sp - 1'b1;
      end else begin
        psr <= (flag_we & flags_in) | (~flag_we & psr);
        if (doSave) sp <= sp + 1'b1;
      end
      if (stackFault) stack_err <= 1'b1;
    end
  end

  // Saved flag sets are not cleared by reset; sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (doSave) stackMem[pushIdx] <= psr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      taken_valid <= 1'b0;
      taken       <= 1'b0;
    end else if (accept) begin
      taken_valid <= 1'b1;
      taken       <= condTrue;
    end else if (taken_ready) begin
      taken_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed bench for alu_flag_unit: a bypassing and a non-bypassing instance share stimulus.
module tb_alu_flag_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] flags_in, flag_we;
  logic       cond_valid, taken_ready, save, restore;
  logic [3:0] cond_code;

  logic       condReadyA, takenValidA, takenA, emptyA, fullA, errA;
  logic [4:0] psrA;
  logic       condReadyB, takenValidB, takenB, emptyB, fullB, errB;
  logic [4:0] psrB;

  int errCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  alu_flag_unit #(.SHADOW_DEPTH(4), .BYPASS(1'b1)) dutA (
    .clk(clk), .reset_n(reset_n), .flags_in(flags_in), .flag_we(flag_we),
    .cond_valid(cond_valid), .cond_code(cond_code), .cond_ready(condReadyA),
    .taken_valid(takenValidA), .taken(takenA), .taken_ready(taken_ready),
    .save(save), .restore(restore), .psr(psrA), .stack_empty(emptyA),
    .stack_full(fullA), .stack_err(errA));

  alu_flag_unit #(.SHADOW_DEPTH(4), .BYPASS(1'b0)) dutB (
    .clk(clk), .reset_n(reset_n), .flags_in(flags_in), .flag_we(flag_we),
    .cond_valid(cond_valid), .cond_code(cond_code), .cond_ready(condReadyB),
    .taken_valid(takenValidB), .taken(takenB), .taken_ready(taken_ready),
    .save(save), .restore(restore), .psr(psrB), .stack_empty(emptyB),
    .stack_full(fullB), .stack_err(errB));

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] we, input logic [4:0] fin, input logic cv,
                               input logic [3:0] code, input logic tr, input logic sv,
                               input logic rs);
    flag_we = we; flags_in = fin; cond_valid = cv; cond_code = code;
    taken_ready = tr; save = sv; restore = rs;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic condModel(input logic [3:0] code, input logic [4:0] f);
    logic c, l, fl, z, n;
    c = f[4]; l = f[3]; fl = f[2]; z = f[1]; n = f[0];
    case (code)
      4'h0: return z;         4'h1: return !z;
      4'h2: return c;         4'h3: return !c;
      4'h4: return l;         4'h5: return !l;
      4'h6: return n;         4'h7: return !n;
      4'h8: return fl;        4'h9: return !fl;
      4'hA: return !l && !z;  4'hB: return l || z;
      4'hC: return !n && !z;  4'hD: return n || z;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    reset_n = 1'b0;
    applyStimulus(5'h00, 5'h00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    #12;
    checkOutput("rst psr", psrA, 5'h00);
    checkOutput("rst taken_valid", takenValidA, 1'b0);
    checkOutput("rst taken", takenA, 1'b0);
    checkOutput("rst empty", emptyA, 1'b1);
    checkOutput("rst full", fullA, 1'b0);
    checkOutput("rst err", errA, 1'b0);
    checkOutput("rst cond_ready", condReadyA, 1'b1);
    @(negedge clk) reset_n = 1'b1;

    // Flag write and EQ request in the same cycle
    applyStimulus(5'h1F, 5'b00010, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(5'h00, 5'h00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("byp1 taken_valid", takenValidA, 1'b1);
    checkOutput("byp1 taken", takenA, 1'b1);
    checkOutput("byp1 psr", psrA, 5'b00010);
    checkOutput("byp0 taken_valid", takenValidB, 1'b1);
    checkOutput("byp0 taken", takenB, 1'b0);
    step();
    checkOutput("drain taken_valid", takenValidA, 1'b0);
    checkOutput("drain taken holds", takenA, 1'b1);

    // Backpressure: only the first of three requests is accepted
    applyStimulus(5'h00, 5'h00, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("bp accept valid", takenValidA, 1'b1);
    checkOutput("bp accept taken", takenA, 1'b1);
    checkOutput("bp cond_ready", condReadyA, 1'b0);
    applyStimulus(5'h00, 5'h00, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      checkOutput("bp hold valid", takenValidA, 1'b1);
      checkOutput("bp hold taken", takenA, 1'b1);
      checkOutput("bp hold ready", condReadyA, 1'b0);
    end
    applyStimulus(5'h00, 5'h00, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("bp release ready", condReadyA, 1'b1);
    step();
    checkOutput("bp next valid", takenValidA, 1'b1);
    checkOutput("bp next taken", takenA, 1'b0);
    applyStimulus(5'h00, 5'h00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    step();

    // Full condition sweep over every flag combination, back-to-back requests
    for (int v = 0; v < 32; v++) begin
      applyStimulus(5'h1F, 5'(v), 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      step();
      for (int c = 0; c < 16; c++) begin
        applyStimulus(5'h00, 5'h00, 1'b1, 4'(c), 1'b1, 1'b0, 1'b0);
        step();
        checkOutput($sformatf("sweepA c%0h psr%0h", c, v), takenA, condModel(4'(c), 5'(v)));
        checkOutput($sformatf("sweepB c%0h psr%0h", c, v), takenB, condModel(4'(c), 5'(v)));
        checkOutput("sweep valid", takenValidA, 1'b1);
      end
    end
    applyStimulus(5'h1F, 5'h15, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    step();

    // Save/restore nesting
    checkOutput("stk psr 15", psrA, 5'h15);
    applyStimulus(5'h1F, 5'h0A, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    step();
    checkOutput("stk save1 psr", psrA, 5'h0A);
    checkOutput("stk save1 empty", emptyA, 1'b0);
    applyStimulus(5'h00, 5'h00, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    step();
    applyStimulus(5'h1F, 5'h1F, 1'b1, 4'h2, 1'b1, 1'b0, 1'b1);
    step();
    checkOutput("stk restore1 psr", psrA, 5'h0A);
    checkOutput("stk restore no bypass", takenA, 1'b0);
    applyStimulus(5'h00, 5'h00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
    step();
    checkOutput("stk restore2 psr", psrA, 5'h15);
    checkOutput("stk restore2 empty", emptyA, 1'b1);
    checkOutput("stk no err", errA, 1'b0);
    applyStimulus(5'h00, 5'h00, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    step();
    applyStimulus(5'h1F, 5'h00, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1);
    step();
    checkOutput("stk save+restore psr", psrA, 5'h15);
    checkOutput("stk save+restore empty", emptyA, 1'b1);
    checkOutput("stk save+restore err", errA, 1'b0);

    // Overflow: each push also loads new flags so pop order is visible
    for (int k = 0; k < 5; k++) begin
      applyStimulus(5'h1F, 5'(k + 1), 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
      step();
      checkOutput("ovf full", fullA, (k >= 3) ? 1'b1 : 1'b0);
      checkOutput("ovf err", errA, (k == 4) ? 1'b1 : 1'b0);
    end
    checkOutput("ovf psr", psrA, 5'h05);
    begin
      logic [4:0] popExp [4];
      popExp[0] = 5'h03; popExp[1] = 5'h02; popExp[2] = 5'h01; popExp[3] = 5'h15;
      for (int k = 0; k < 4; k++) begin
        applyStimulus(5'h00, 5'h00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
        step();
        checkOutput($sformatf("pop %0d psr", k), psrA, popExp[k]);
      end
    end
    checkOutput("pop empty", emptyA, 1'b1);
    applyStimulus(5'h00, 5'h00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
    step();
    checkOutput("underflow err", errA, 1'b1);
    checkOutput("underflow psr", psrA, 5'h15);
    checkOutput("underflow empty", emptyA, 1'b1);

    // Reset asserted while a result is waiting
    applyStimulus(5'h00, 5'h00, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("mid valid before", takenValidA, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("mid rst valid", takenValidA, 1'b0);
    checkOutput("mid rst taken", takenA, 1'b0);
    checkOutput("mid rst psr", psrA, 5'h00);
    checkOutput("mid rst err", errA, 1'b0);
    checkOutput("mid rst empty", emptyA, 1'b1);
    checkOutput("mid rst B valid", takenValidB, 1'b0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
